// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared types for the display write path. Defines the video
//                memory bank encoding, the buffered write entry and helper
//                functions for bank validation and one-hot strobe generation.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam int NUM_BANKS = 5;

    typedef enum logic [2:0] {
        BANK_OAM     = 3'd0,
        BANK_SPRITE  = 3'd1,
        BANK_TILE    = 3'd2,
        BANK_PALETTE = 3'd3,
        BANK_TAM     = 3'd4
    } bank_e;

    typedef struct packed {
        bank_e       bank;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_entry_t;

    localparam int ENTRY_W = $bits(wr_entry_t);

    // Bank codes 5..7 carry no memory behind them.
    function automatic logic bank_valid(input logic [2:0] bank);
        return (bank < 3'(NUM_BANKS));
    endfunction

    // One-hot write enable for a bank code; all-zero for invalid codes.
    function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [2:0] bank);
        logic [NUM_BANKS-1:0] v;
        v = '0;
        if (bank_valid(bank)) begin
            v = NUM_BANKS'(1) << bank;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO, parameterised width and depth (power of
//                two). Storage is written on the clock edge, so an entry
//                pushed in cycle N is presented on o_rdata from cycle N+1.
//                Pointers wrap naturally; a push while full is only taken if
//                a pop happens in the same cycle.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_push, i_wdata - write request and data
//                i_pop           - consume the head entry
//                o_rdata         - head entry
//                o_full, o_empty - occupancy flags
//                o_level         - number of stored entries (0..DEPTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int                  c_addr_w  = $clog2(DEPTH);
    localparam logic [c_addr_w:0]   c_depth   = (c_addr_w+1)'(DEPTH);
    localparam logic [c_addr_w:0]   c_lvl_one = (c_addr_w+1)'(1);
    localparam logic [c_addr_w-1:0] c_ptr_one = c_addr_w'(1);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_level;
    logic                w_push;
    logic                w_pop;

    // Illegal requests are masked here so the level can never leave 0..DEPTH.
    assign w_pop  = i_pop && (r_level != '0);
    assign w_push = i_push && ((r_level != c_depth) || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_level == c_depth);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/ebi_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ebi_write_scheduler
//  Description : Buffers MCU writes from ebi_interface and replays them in
//                order to the video memories as one-hot write strobes on a
//                shared address/data bus. Banks flagged in DEFER_MASK are only
//                written while vblank is high; a deferred head blocks all
//                younger entries.
//  Ports       : clk, reset            - pixel clock, sync active-high reset
//                in_valid/addr/data/bank - write pulse from ebi_interface
//                vblank                - vertical blanking level
//                ovf_clr               - clears overflow and bad_bank
//                wr_addr, wr_data, we  - registered memory write port
//                level, full           - FIFO occupancy
//                overflow, bad_bank    - sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module ebi_write_scheduler
    import display_pkg::*;
#(
    parameter int                   DEPTH      = 64,
    parameter logic [NUM_BANKS-1:0] DEFER_MASK = 5'b11111
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [15:0]            in_addr,
    input  logic [15:0]            in_data,
    input  logic [2:0]             in_bank,
    input  logic                   vblank,
    input  logic                   ovf_clr,
    output logic [15:0]            wr_addr,
    output logic [15:0]            wr_data,
    output logic [NUM_BANKS-1:0]   we,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   overflow,
    output logic                   bad_bank
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    // Mask widened to cover all eight bank codes so invalid codes index safely.
    localparam logic [7:0] c_defer_ext = {3'b000, DEFER_MASK};

    logic [ENTRY_W-1:0]    w_in_word;
    logic [ENTRY_W-1:0]    w_rdata;
    wr_entry_t             w_head;
    logic [2:0]            w_head_bank;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_head_eligible;
    logic [1:0]            w_state;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [NUM_BANKS-1:0]  r_we;
    logic [15:0]           r_addr;
    logic [15:0]           r_data;
    logic                  r_overflow;
    logic                  r_bad_bank;

    assign w_in_word   = {in_bank, in_addr, in_data};
    assign w_head      = wr_entry_t'(w_rdata);
    assign w_head_bank = w_head.bank;

    // Invalid banks are always eligible so they never stall the queue.
    assign w_head_eligible = !bank_valid(w_head_bank)
                           || !c_defer_ext[w_head_bank]
                           || vblank;

    // The scheduler state is a pure function of the registered occupancy and
    // the current head eligibility. This makes HOLD->DRAIN take effect in the
    // very cycle vblank rises, and DRAIN->HOLD as soon as an ineligible entry
    // reaches the head, with no extra cycle of state-register latency.
    always_comb begin
        w_state = S_IDLE;
        if (!w_empty) begin
            w_state = w_head_eligible ? S_DRAIN : S_HOLD;
        end
    end

    assign w_pop  = (w_state == S_DRAIN);
    assign w_push = in_valid && (!w_full || w_pop);
    assign w_drop = in_valid && w_full && !w_pop;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_in_word),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    // Output register: a pop in cycle N strobes in cycle N+1; address and
    // data hold between strobes. Error flag sets take priority over clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we       <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_overflow <= 1'b0;
            r_bad_bank <= 1'b0;
        end else begin
            r_we <= '0;
            if (w_pop && bank_valid(w_head_bank)) begin
                r_we   <= bank_onehot(w_head_bank);
                r_addr <= w_head.addr;
                r_data <= w_head.data;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end

            if (w_pop && !bank_valid(w_head_bank)) begin
                r_bad_bank <= 1'b1;
            end else if (ovf_clr) begin
                r_bad_bank <= 1'b0;
            end
        end
    end

    assign we       = r_we;
    assign wr_addr  = r_addr;
    assign wr_data  = r_data;
    assign full     = w_full;
    assign overflow = r_overflow;
    assign bad_bank = r_bad_bank;

endmodule
`default_nettype wire

// File: tb/tb_ebi_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ebi_write_scheduler
//  Description : Self-checking bench for ebi_write_scheduler. Three instances
//                with different defer masks share the data inputs and have
//                private valid strobes. A scoreboard per instance holds the
//                strobes expected on the write port; timing-exact checks are
//                made in a vector table and hand-written sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ebi_write_scheduler;
    import display_pkg::*;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [4:0]  we;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    typedef struct packed {
        logic [2:0]  bank;
        logic [15:0] addr;
        logic [15:0] data;
        logic [4:0]  exp_we;
        logic        exp_bad;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        val_a, val_b, val_c;
    logic [15:0] in_addr, in_data;
    logic [2:0]  in_bank;
    logic        vblank, ovf_clr;

    logic [15:0]   a_addr, a_data, b_addr, b_data, c_addr, c_data;
    logic [4:0]    a_we, b_we, c_we;
    logic [LW-1:0] a_level, b_level, c_level;
    logic          a_full, b_full, c_full;
    logic          a_ovf, b_ovf, c_ovf;
    logic          a_bad, b_bad, c_bad;

    int   checks   = 0;
    int   failures = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    vec_t vecs[6];

    always #5 clk = ~clk;

    ebi_write_scheduler #(.DEPTH(DEPTH), .DEFER_MASK(5'b00000)) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(val_a), .in_addr(in_addr), .in_data(in_data),
        .in_bank(in_bank), .vblank(vblank), .ovf_clr(ovf_clr), .wr_addr(a_addr),
        .wr_data(a_data), .we(a_we), .level(a_level), .full(a_full), .overflow(a_ovf),
        .bad_bank(a_bad));

    ebi_write_scheduler #(.DEPTH(DEPTH), .DEFER_MASK(5'b11111)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(val_b), .in_addr(in_addr), .in_data(in_data),
        .in_bank(in_bank), .vblank(vblank), .ovf_clr(ovf_clr), .wr_addr(b_addr),
        .wr_data(b_data), .we(b_we), .level(b_level), .full(b_full), .overflow(b_ovf),
        .bad_bank(b_bad));

    ebi_write_scheduler #(.DEPTH(DEPTH), .DEFER_MASK(5'b00001)) u_dut_c (
        .clk(clk), .reset(reset), .in_valid(val_c), .in_addr(in_addr), .in_data(in_data),
        .in_bank(in_bank), .vblank(vblank), .ovf_clr(ovf_clr), .wr_addr(c_addr),
        .wr_data(c_data), .we(c_we), .level(c_level), .full(c_full), .overflow(c_ovf),
        .bad_bank(c_bad));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one write pulse into instance idx; record the expected strobe.
    task automatic push(input int idx, input logic [2:0] bank, input logic [15:0] addr,
                        input logic [15:0] data, input bit expect_out);
        exp_t e;
        in_bank = bank;
        in_addr = addr;
        in_data = data;
        case (idx)
            0:       val_a = 1'b1;
            1:       val_b = 1'b1;
            default: val_c = 1'b1;
        endcase
        if (expect_out && bank < 3'd5) begin
            e.we   = 5'(1) << bank;
            e.addr = addr;
            e.data = data;
            case (idx)
                0:       q_a.push_back(e);
                1:       q_b.push_back(e);
                default: q_c.push_back(e);
            endcase
        end
        step();
        val_a = 1'b0;
        val_b = 1'b0;
        val_c = 1'b0;
    endtask

    task automatic mon(input int idx, input logic [4:0] we, input logic [15:0] addr,
                       input logic [15:0] data);
        exp_t e;
        bit   have;
        have = 1'b0;
        e    = '0;
        if (we !== 5'b00000) begin
            checks++;
            case (idx)
                0: if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
                1: if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
                default: if (q_c.size() > 0) begin e = q_c.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                failures++;
                $display("FAIL sb_unexpected[%0d] actual we=%b addr=%h data=%h required no strobe",
                         idx, we, addr, data);
            end else if (we !== e.we || addr !== e.addr || data !== e.data) begin
                failures++;
                $display("FAIL sb_order[%0d] actual we=%b addr=%h data=%h required we=%b addr=%h data=%h",
                         idx, we, addr, data, e.we, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_we, a_addr, a_data);
        mon(1, b_we, b_addr, b_data);
        mon(2, c_we, c_addr, c_data);
    end

    initial begin
        logic [15:0] last_addr;
        logic [15:0] last_data;
        vec_t        v;

        vecs[0] = '{3'd1, 16'h0010, 16'hBEEF, 5'b00010, 1'b0};
        vecs[1] = '{3'd0, 16'h0001, 16'h1111, 5'b00001, 1'b0};
        vecs[2] = '{3'd2, 16'h0002, 16'h2222, 5'b00100, 1'b0};
        vecs[3] = '{3'd3, 16'h0003, 16'h3333, 5'b01000, 1'b0};
        vecs[4] = '{3'd4, 16'h0004, 16'h4444, 5'b10000, 1'b0};
        vecs[5] = '{3'd6, 16'h0666, 16'h6666, 5'b00000, 1'b1};

        reset = 1'b1; val_a = 1'b0; val_b = 1'b0; val_c = 1'b0;
        in_addr = '0; in_data = '0; in_bank = '0; vblank = 1'b0; ovf_clr = 1'b0;
        repeat (3) step();

        // Reset state; a write pulse during reset is ignored.
        chk("rst_level", b_level, 0);
        chk("rst_full", b_full, 0);
        chk("rst_we", b_we, 0);
        chk("rst_addr", b_addr, 0);
        chk("rst_data", b_data, 0);
        chk("rst_ovf", b_ovf, 0);
        chk("rst_bad", b_bad, 0);
        push(0, 3'd1, 16'hDEAD, 16'hDEAD, 1'b0);
        chk("rst_push_ignored", a_level, 0);
        reset = 1'b0;
        repeat (5) step();

        // Vector table on the undeferred instance: strobe exactly at N+2.
        last_addr = 16'h0000;
        last_data = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            push(0, v.bank, v.addr, v.data, 1'b1);
            chk("t1_level", a_level, 1);
            chk("t1_we_early", a_we, 0);
            step();
            if (v.exp_we != 5'b00000) begin
                last_addr = v.addr;
                last_data = v.data;
            end
            chk("t1_we", a_we, v.exp_we);
            chk("t1_addr", a_addr, last_addr);
            chk("t1_data", a_data, last_data);
            chk("t1_bad", a_bad, v.exp_bad);
            step();
            chk("t1_we_pulse", a_we, 0);
        end

        // Deferred banks wait for vblank, then drain on consecutive cycles.
        push(1, 3'd0, 16'h0100, 16'h1000, 1'b1);
        push(1, 3'd3, 16'h0103, 16'h1003, 1'b1);
        push(1, 3'd4, 16'h0104, 16'h1004, 1'b1);
        repeat (3) step();
        chk("t2_level_held", b_level, 3);
        chk("t2_we_held", b_we, 0);
        vblank = 1'b1;
        step();
        chk("t2_we0", b_we, 5'b00001);
        chk("t2_addr0", b_addr, 16'h0100);
        step();
        chk("t2_we1", b_we, 5'b01000);
        step();
        chk("t2_we2", b_we, 5'b10000);
        chk("t2_level_empty", b_level, 0);
        step();
        chk("t2_we_idle", b_we, 0);
        vblank = 1'b0;

        // A deferred OAM head blocks an undeferred TILE write behind it.
        push(2, 3'd0, 16'h0300, 16'hC000, 1'b1);
        push(2, 3'd2, 16'h0302, 16'hC002, 1'b1);
        repeat (4) step();
        chk("t3_level_blocked", c_level, 2);
        chk("t3_we_blocked", c_we, 0);
        vblank = 1'b1;
        step();
        chk("t3_we_oam", c_we, 5'b00001);
        chk("t3_addr_oam", c_addr, 16'h0300);
        step();
        chk("t3_we_tile", c_we, 5'b00100);
        chk("t3_addr_tile", c_addr, 16'h0302);
        vblank = 1'b0;
        step();
        chk("t3_level_empty", c_level, 0);

        // Overflow: DEPTH+2 writes, last two lost; push while full with pop accepted.
        for (int i = 0; i < DEPTH + 2; i++) begin
            push(1, 3'd2, 16'h4000 + 16'(i), 16'hA000 + 16'(i), i < DEPTH);
            if (i == DEPTH - 1) begin
                chk("t4_full_at_depth", b_full, 1);
                chk("t4_no_ovf_yet", b_ovf, 0);
            end
        end
        chk("t4_full", b_full, 1);
        chk("t4_level", b_level, DEPTH);
        chk("t4_ovf", b_ovf, 1);
        vblank = 1'b1;
        push(1, 3'd2, 16'h4FFF, 16'hFFFF, 1'b1);
        chk("t4_push_on_pop", b_level, DEPTH);
        chk("t4_no_extra_ovf", b_ovf, 1);
        repeat (DEPTH + 3) step();
        chk("t4_drained", b_level, 0);
        chk("t4_not_full", b_full, 0);
        chk("t4_sb_empty", q_b.size(), 0);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t4_ovf_clr", b_ovf, 0);

        // Invalid bank discarded between two TILE writes.
        chk("t5_bad_before", b_bad, 0);
        push(1, 3'd2, 16'h5000, 16'h5500, 1'b1);
        push(1, 3'd6, 16'h5006, 16'h5566, 1'b1);
        push(1, 3'd2, 16'h5002, 16'h5522, 1'b1);
        repeat (4) step();
        chk("t5_bad", b_bad, 1);
        chk("t5_level", b_level, 0);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t5_bad_clr", b_bad, 0);
        push(1, 3'd7, 16'h7777, 16'h0000, 1'b1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t5_set_beats_clr", b_bad, 1);
        vblank = 1'b0;

        // Reset in the middle of a drain discards everything queued.
        for (int i = 0; i < 12; i++) begin
            push(1, 3'd1, 16'h6000 + 16'(i), 16'h6600 + 16'(i), 1'b1);
        end
        chk("t6_level_full12", b_level, 12);
        vblank = 1'b1;
        step();
        step();
        chk("t6_level_draining", b_level, 10);
        reset = 1'b1;
        step();
        chk("t6_we_reset", b_we, 0);
        chk("t6_level_reset", b_level, 0);
        q_a.delete();
        q_b.delete();
        q_c.delete();
        reset = 1'b0;
        repeat (20) step();
        chk("t6_level_after", b_level, 0);
        vblank = 1'b0;
        step();
        chk("end_sb_empty", q_a.size() + q_b.size() + q_c.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
